// File: rtl/uart_tx_pkg.sv
//==============================================================================
// Module   : uart_tx_pkg
// Purpose  : Shared definitions for the UART transmit framer: line levels and
//            the framer state encoding.
// Config   : UART_TX_TWO_STOP_EN adds the STOP2 state to the encoding.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package uart_tx_pkg;

    // Serial line levels
    localparam logic TX_IDLE_LEVEL = 1'b1;
    localparam logic START_LEVEL   = 1'b0;

    // Framer states; STOP2 exists only in the two-stop-bit build
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
`ifdef UART_TX_TWO_STOP_EN
        ,
        STOP2  = 3'd5
`endif
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_frame_ctrl_if.sv
//==============================================================================
// Module   : uart_tx_frame_ctrl_if
// Purpose  : Payload request and serial-line bundle of the UART TX framer.
//            master = payload source / line observer, slave = framer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface uart_tx_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_bit;
    logic                  tx_out;
    logic                  busy;

    modport master (
        output p_data, data_valid, par_en, par_bit,
        input  tx_out, busy
    );

    modport slave (
        input  p_data, data_valid, par_en, par_bit,
        output tx_out, busy
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_serializer.sv
//==============================================================================
// Module   : uart_tx_serializer
// Purpose  : Payload bit selector for the UART TX framer. Holds the bit
//            counter and presents the payload bit that the framer will drive
//            on the line after the next clock edge (indexed mux, no shifting).
//            o_done flags that the last payload bit is currently on the line.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst,        // asynchronous, active-low
    input  wire logic [DATA_WIDTH-1:0] i_data,
    input  wire logic                  i_clr,      // hold counter at bit 0
    input  wire logic                  i_adv,      // step to next payload bit
    output logic                       o_bit_nxt,
    output logic                       o_done
);

    localparam int              CNT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_WIDTH - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Next counter value: cleared outside DATA, saturates at the last bit
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = '0;
        end else if (i_adv && (r_cnt != C_LAST)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    // Bit counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // The framer registers its line output, so it needs the bit for the
    // counter value that becomes current on the next edge.
    assign o_bit_nxt = i_data[w_cnt_nxt];
    assign o_done    = (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_tx_frame_ctrl.sv
//==============================================================================
// Module   : uart_tx_frame_ctrl
// Purpose  : UART transmit framer. Accepts a parallel payload and sends
//            start / LSB-first data / optional parity / stop bits, one bit
//            per baud clock. tx_out and busy are registered and decoded from
//            the next state, so the start bit appears the cycle after accept.
//            Back-to-back frames are accepted in the last stop cycle.
// Config   : UART_TX_TWO_STOP_EN - send two stop bits (adds STOP2).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_tx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,      // asynchronous, active-low
    uart_tx_frame_ctrl_if.slave bus
);

    import uart_tx_pkg::*;

    tx_state_t             r_state;
    tx_state_t             w_state_nxt;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  r_tx_out;
    logic                  r_busy;
    logic                  w_tx_nxt;
    logic                  w_busy_nxt;
    logic                  w_last_stop;
    logic                  w_accept;
    logic                  w_ser_clr;
    logic                  w_ser_adv;
    logic                  w_ser_bit;
    logic                  w_ser_done;

`ifdef UART_TX_TWO_STOP_EN
    assign w_last_stop = (r_state == STOP2);
`else
    assign w_last_stop = (r_state == STOP);
`endif

    // A new payload is taken only when idle or on the final stop cycle
    assign w_accept  = bus.data_valid && ((r_state == IDLE) || w_last_stop);

    assign w_ser_clr = (r_state != DATA);
    assign w_ser_adv = (r_state == DATA);

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .clk       (clk),
        .rst       (rst),
        .i_data    (r_data),
        .i_clr     (w_ser_clr),
        .i_adv     (w_ser_adv),
        .o_bit_nxt (w_ser_bit),
        .o_done    (w_ser_done)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and next-cycle line/busy decode
    always_comb begin
        w_state_nxt = IDLE;
        w_tx_nxt    = TX_IDLE_LEVEL;
        w_busy_nxt  = 1'b0;

        case (r_state)
            IDLE:    w_state_nxt = bus.data_valid ? START : IDLE;
            START:   w_state_nxt = DATA;
            DATA: begin
                if (w_ser_done) begin
                    w_state_nxt = r_par_en ? PARITY : STOP;
                end else begin
                    w_state_nxt = DATA;
                end
            end
            PARITY:  w_state_nxt = STOP;
`ifdef UART_TX_TWO_STOP_EN
            STOP:    w_state_nxt = STOP2;
            STOP2:   w_state_nxt = bus.data_valid ? START : IDLE;
`else
            STOP:    w_state_nxt = bus.data_valid ? START : IDLE;
`endif
            default: w_state_nxt = IDLE;
        endcase

        case (w_state_nxt)
            START: begin
                w_tx_nxt   = START_LEVEL;
                w_busy_nxt = 1'b1;
            end
            DATA: begin
                w_tx_nxt   = w_ser_bit;
                w_busy_nxt = 1'b1;
            end
            PARITY: begin
                w_tx_nxt   = r_par_bit;
                w_busy_nxt = 1'b1;
            end
            STOP: begin
                w_tx_nxt   = TX_IDLE_LEVEL;
                w_busy_nxt = 1'b1;
            end
`ifdef UART_TX_TWO_STOP_EN
            STOP2: begin
                w_tx_nxt   = TX_IDLE_LEVEL;
                w_busy_nxt = 1'b1;
            end
`endif
            IDLE: begin
                w_tx_nxt   = TX_IDLE_LEVEL;
                w_busy_nxt = 1'b0;
            end
            default: begin
                w_tx_nxt   = TX_IDLE_LEVEL;
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // Payload/parity latches and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data    <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_tx_out  <= TX_IDLE_LEVEL;
            r_busy    <= 1'b0;
        end else begin
            r_tx_out <= w_tx_nxt;
            r_busy   <= w_busy_nxt;
            if (w_accept) begin
                r_data   <= bus.p_data;
                r_par_en <= bus.par_en;
            end
            // The parity stage delivers its bit one cycle after accept
            if (r_state == START) begin
                r_par_bit <= bus.par_bit;
            end
        end
    end

    assign bus.tx_out = r_tx_out;
    assign bus.busy   = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_frame_ctrl.sv
//==============================================================================
// Module   : tb_uart_tx_frame_ctrl
// Purpose  : Scoreboard bench for uart_tx_frame_ctrl. Each accepted payload
//            queues its hand-written expected line sequence; a negedge
//            monitor pops one bit per busy cycle and otherwise expects idle.
// Config   : UART_TX_TWO_STOP_EN - expected frames carry a second stop bit.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_tx_frame_ctrl;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    uart_tx_frame_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_frame_ctrl #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic exp_q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s @%0t: busy,tx_out=%b required %b", name, $time, act, req);
        end
    endtask

    function automatic string add_stop(input string s);
`ifdef UART_TX_TWO_STOP_EN
        return {s, "1"};
`else
        return s;
`endif
    endfunction

    task automatic push_frame(input string s);
        for (int i = 0; i < s.len(); i++) begin
            exp_q.push_back(s[i] == 8'h31);
        end
    endtask

    // Accept a payload; parity bit is driven only during the START cycle
    task automatic send(input logic [7:0] d, input logic pe, input logic pb, input string frame);
        bus.p_data     = d;
        bus.par_en     = pe;
        bus.par_bit    = ~pb;
        bus.data_valid = 1'b1;
        @(posedge clk); #1;
        bus.data_valid = 1'b0;
        bus.par_bit    = pb;
        push_frame(frame);
        @(posedge clk); #1;
        bus.par_bit    = ~pb;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst && mon_en) begin
            if (exp_q.size() > 0) begin
                logic e;
                e = exp_q.pop_front();
                check("frame_bit", {bus.busy, bus.tx_out}, {1'b1, e});
            end else begin
                check("idle", {bus.busy, bus.tx_out}, 2'b01);
            end
        end
    end

    initial begin
        string f;
        bus.p_data     = '0;
        bus.data_valid = 1'b0;
        bus.par_en     = 1'b0;
        bus.par_bit    = 1'b0;

        // Reset state
        repeat (3) @(posedge clk); #1;
        check("reset", {bus.busy, bus.tx_out}, 2'b01);
        rst    = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(posedge clk); #1;

        // A5, no parity
        send(8'hA5, 1'b0, 1'b0, add_stop("0101001011"));
        repeat (12) @(posedge clk); #1;

        // 5A, parity bit 0
        send(8'h5A, 1'b1, 1'b0, add_stop("00101101001"));
        repeat (12) @(posedge clk); #1;

        // Back-to-back: FF requested during the last stop cycle of A5
        f = add_stop("0101001011");
        send(8'hA5, 1'b0, 1'b0, f);
        repeat (f.len() - 2) @(posedge clk); #1;
        send(8'hFF, 1'b0, 1'b0, add_stop("0111111111"));
        repeat (12) @(posedge clk); #1;

        // 3C with parity; a 00 request mid-frame must be ignored
        send(8'h3C, 1'b1, 1'b0, add_stop("00011110001"));
        repeat (2) @(posedge clk); #1;
        bus.p_data     = 8'h00;
        bus.par_en     = 1'b0;
        bus.data_valid = 1'b1;
        @(posedge clk); #1;
        bus.data_valid = 1'b0;
        repeat (14) @(posedge clk); #1;

        // Reset asserted mid-frame
        send(8'hA5, 1'b0, 1'b0, add_stop("0101001011"));
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_midframe", {bus.busy, bus.tx_out}, 2'b01);
        exp_q.delete();
        @(posedge clk); #1;
        check("rst_held", {bus.busy, bus.tx_out}, 2'b01);
        rst = 1'b1;
        repeat (5) @(posedge clk); #1;

        // All expected bits consumed
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drained: %0d entries left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
